// File: rtl/cdc_afifo_arb_pkg.sv
// Shared types for the cdc_afifo write-side arbiter and its round-robin picker.
// Only fixed-width registers live in the struct; index-sized registers stay in the top.
package cdc_afifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e state;
        logic [7:0] beat_cnt;
        logic [7:0] idle_cnt;
    } arb_ctl_t;

    localparam arb_ctl_t ctl_rst = '{state: IDLE, beat_cnt: 8'd0, idle_cnt: 8'd0};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_afifo_wr_arb_if.sv
// Requester, FIFO write-port and status bundle of the write-side arbiter.
// slave = arbiter side, master = requesters / FIFO / observer side.
interface cdc_afifo_wr_arb_if #(
    parameter int nreq  = 4,
    parameter int dbits = 32
);
    import cdc_afifo_arb_pkg::*;

    localparam int idw = idx_width(nreq);

    logic [nreq-1:0]       i_req_valid;
    logic [nreq-1:0]       i_req_last;
    logic [nreq*dbits-1:0] i_req_data;
    logic [nreq-1:0]       o_req_ready;
    logic                  o_wr;
    logic [idw+dbits-1:0]  o_wdata;
    logic                  i_wfull;
    logic [idw-1:0]        o_grant_id;
    logic                  o_busy;
    logic [nreq-1:0]       o_trunc;

    modport slave (
        input  i_req_valid, i_req_last, i_req_data, i_wfull,
        output o_req_ready, o_wr, o_wdata, o_grant_id, o_busy, o_trunc
    );

    modport master (
        output i_req_valid, i_req_last, i_req_data, i_wfull,
        input  o_req_ready, o_wr, o_wdata, o_grant_id, o_busy, o_trunc
    );

endinterface

// File: rtl/cdc_afifo_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo nreq.
// The request vector is doubled and rotated so the search is a plain lowest-set-bit scan.
module cdc_afifo_rr_pick
    import cdc_afifo_arb_pkg::*;
#(
    parameter int nreq = 4,
    localparam int idw = idx_width(nreq)
) (
    input  logic [nreq-1:0] req,
    input  logic [idw-1:0]  ptr,
    output logic            found,
    output logic [idw-1:0]  idx
);

    logic [2*nreq-1:0] dbl;
    logic [nreq-1:0]   rot;
    int                sel;

    always_comb begin
        dbl   = {req, req};
        rot   = nreq'(dbl >> (int'(ptr) + 1));
        found = |rot;
        idx   = '0;
        sel   = 0;
        // descending scan so the nearest candidate after ptr is the one left standing
        for (int j = nreq - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sel = int'(ptr) + 1 + j;
                if (sel >= nreq) sel = sel - nreq;
                idx = idw'(sel);
            end
        end
    end

endmodule

// File: rtl/cdc_afifo_wr_arb.sv
// Write-side arbiter for one cdc_afifo: round-robin grants with burst locking,
// forced release on burst length or requester idle timeout; beats tagged with source index.
//
// state | meaning
// IDLE  | arbitrate among valid requesters, no beat accepted
// BURST | granted requester owns the FIFO write port until last/maxburst/timeout
module cdc_afifo_wr_arb
    import cdc_afifo_arb_pkg::*;
#(
    parameter int nreq     = 4,
    parameter int dbits    = 32,
    parameter int maxburst = 16,
    parameter int tmo      = 8
) (
    input  logic                     i_wclk,
    input  logic                     i_nrst,
    cdc_afifo_wr_arb_if.slave        bus
);

    localparam int         idw       = idx_width(nreq);
    localparam logic [7:0] last_beat = 8'(maxburst - 1);
    localparam logic [7:0] last_idle = 8'(tmo - 1);

    arb_ctl_t          ctl_q, ctl_d;
    logic [idw-1:0]    gid_q, gid_d;
    logic [idw-1:0]    rr_q, rr_d;
    logic [nreq-1:0]   trunc_q, trunc_d;
    logic [nreq-1:0]   ready;
    logic [dbits-1:0]  data_arr [nreq];
    logic              pick_found;
    logic [idw-1:0]    pick_idx;
    logic              vld_g;
    logic              last_g;
    logic              xfer;
    logic              end_burst;

    cdc_afifo_rr_pick #(.nreq(nreq)) u_pick (
        .req   (bus.i_req_valid),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int k = 0; k < nreq; k++) begin
            data_arr[k] = bus.i_req_data[k*dbits +: dbits];
        end
    end

    always_comb begin
        ctl_d     = ctl_q;
        gid_d     = gid_q;
        rr_d      = rr_q;
        trunc_d   = trunc_q;
        ready     = '0;
        xfer      = 1'b0;
        end_burst = 1'b0;
        vld_g     = bus.i_req_valid[gid_q];
        last_g    = bus.i_req_last[gid_q];
        case (ctl_q.state)
            IDLE: begin
                if (pick_found) begin
                    gid_d          = pick_idx;
                    ctl_d.state    = BURST;
                    ctl_d.beat_cnt = 8'd0;
                    ctl_d.idle_cnt = 8'd0;
                end
            end
            BURST: begin
                xfer         = vld_g & ~bus.i_wfull;
                ready[gid_q] = xfer;
                if (xfer) begin
                    ctl_d.beat_cnt = ctl_q.beat_cnt + 8'd1;
                    ctl_d.idle_cnt = 8'd0;
                    // last wins over the length limit, so a full-length burst is not flagged
                    if (last_g) begin
                        end_burst = 1'b1;
                    end else if (ctl_q.beat_cnt == last_beat) begin
                        end_burst      = 1'b1;
                        trunc_d[gid_q] = 1'b1;
                    end
                end else if (!vld_g) begin
                    ctl_d.idle_cnt = ctl_q.idle_cnt + 8'd1;
                    if (ctl_q.idle_cnt == last_idle) begin
                        end_burst      = 1'b1;
                        trunc_d[gid_q] = 1'b1;
                    end
                end
                if (end_burst) begin
                    ctl_d.state = IDLE;
                    rr_d        = gid_q;
                end
            end
            default: ctl_d = ctl_rst;
        endcase
    end

    always_ff @(posedge i_wclk or negedge i_nrst) begin
        if (!i_nrst) begin
            ctl_q   <= ctl_rst;
            gid_q   <= '0;
            rr_q    <= idw'(nreq - 1);
            trunc_q <= '0;
        end else begin
            ctl_q   <= ctl_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_wr        = xfer;
    assign bus.o_wdata     = {gid_q, data_arr[gid_q]};
    assign bus.o_grant_id  = gid_q;
    assign bus.o_busy      = (ctl_q.state == BURST);
    assign bus.o_trunc     = trunc_q;

endmodule

// File: tb/tb_cdc_afifo_wr_arb.sv
// Bench for cdc_afifo_wr_arb: per-requester source queues, a FIFO occupancy model for
// backpressure, and a scoreboard of hand-ordered expected write words.
module tb_cdc_afifo_wr_arb;

    localparam int nreq  = 4;
    localparam int dbits = 32;
    localparam int idw   = 2;

    logic wclk = 1'b0;
    logic nrst = 1'b0;

    always #5 wclk = ~wclk;

    cdc_afifo_wr_arb_if #(.nreq(nreq), .dbits(dbits)) bus ();

    cdc_afifo_wr_arb #(.nreq(nreq), .dbits(dbits), .maxburst(16), .tmo(8)) dut (
        .i_wclk (wclk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    logic [dbits:0]       srcq [nreq][$];
    logic [idw+dbits-1:0] expq [$];
    int                   wr_cycs [$];
    int                   checks   = 0;
    int                   failures = 0;
    int                   wr_total = 0;
    int                   cyc      = 0;
    int                   fcnt     = 0;
    logic                 rd_en    = 1'b1;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input int k, input logic [31:0] d, input bit last);
        srcq[k].push_back({last, d});
    endtask

    task automatic expect_beat(input int k, input logic [31:0] d);
        expq.push_back({idw'(k), d});
    endtask

    task automatic drive_inputs();
        logic [nreq-1:0]       v;
        logic [nreq-1:0]       l;
        logic [nreq*dbits-1:0] d;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < nreq; k++) begin
            if (srcq[k].size() > 0) begin
                v[k]               = 1'b1;
                l[k]               = srcq[k][0][dbits];
                d[k*dbits +: dbits] = srcq[k][0][dbits-1:0];
            end
        end
        bus.i_req_valid = v;
        bus.i_req_last  = l;
        bus.i_req_data  = d;
    endtask

    // requesters + FIFO occupancy: sample handshakes mid-cycle, act just after the edge
    initial begin
        logic [nreq-1:0] rdy;
        logic            wr_s;
        bus.i_wfull = 1'b0;
        drive_inputs();
        forever begin
            @(negedge wclk);
            rdy  = bus.o_req_ready;
            wr_s = bus.o_wr;
            @(posedge wclk);
            #1;
            for (int k = 0; k < nreq; k++) begin
                if (rdy[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
            end
            if (wr_s) fcnt++;
            if (rd_en && fcnt > 0) fcnt--;
            bus.i_wfull = (fcnt >= 8);
            drive_inputs();
        end
    end

    // scoreboard monitor
    initial begin
        logic [idw+dbits-1:0] e;
        forever begin
            @(negedge wclk);
            if (bus.o_wr === 1'b1) begin
                check("wr_while_full", bus.i_wfull, 64'd0);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%0h required=none", bus.o_wdata);
                end else begin
                    e = expq.pop_front();
                    check("sb_wdata", bus.o_wdata, e);
                end
                wr_total++;
                wr_cycs.push_back(cyc);
            end
        end
    end

    task automatic wait_wr(input int target, input int budget, input string name);
        int n = 0;
        while (wr_total < target && n < budget) begin
            @(negedge wclk);
            #1;
            n++;
        end
        checks++;
        if (wr_total < target) begin
            failures++;
            $display("FAIL %s timeout writes=%0d required=%0d", name, wr_total, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            @(negedge wclk);
            #1;
            n++;
            done = (bus.o_busy == 1'b0) && (expq.size() == 0) && (fcnt == 0) &&
                   (srcq[0].size() == 0) && (srcq[1].size() == 0) &&
                   (srcq[2].size() == 0) && (srcq[3].size() == 0);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout busy=%0b pending_exp=%0d required=idle", name, bus.o_busy, expq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int s;
        int n;

        // reset held while requester 1 already has traffic
        nrst = 1'b0;
        send(1, 32'hA0, 1'b0); send(1, 32'hA1, 1'b0); send(1, 32'hA2, 1'b1);
        expect_beat(1, 32'hA0); expect_beat(1, 32'hA1); expect_beat(1, 32'hA2);
        #1;
        check("rst_wr", bus.o_wr, 64'd0);
        check("rst_ready", bus.o_req_ready, 64'd0);
        check("rst_busy", bus.o_busy, 64'd0);
        check("rst_gid", bus.o_grant_id, 64'd0);
        check("rst_trunc", bus.o_trunc, 64'd0);
        repeat (2) @(negedge wclk);
        check("rst_traffic_valid", bus.i_req_valid, 64'h2);
        check("rst_traffic_ready", bus.o_req_ready, 64'd0);
        check("rst_traffic_busy", bus.o_busy, 64'd0);
        nrst = 1'b1;
        #1;
        check("rel_busy", bus.o_busy, 64'd0);
        check("rel_ready", bus.o_req_ready, 64'd0);
        check("rel_wr", bus.o_wr, 64'd0);

        // single burst: grant registered one cycle after valid
        @(negedge wclk);
        check("single_busy", bus.o_busy, 64'd1);
        check("single_gid", bus.o_grant_id, 64'd1);
        check("single_ready", bus.o_req_ready, 64'h2);
        repeat (2) @(negedge wclk);
        check("single_last_ready", bus.o_req_ready, 64'h2);
        @(negedge wclk);
        check("single_end_busy", bus.o_busy, 64'd0);
        check("single_end_wr", bus.o_wr, 64'd0);
        wait_wr(3, 10, "single_writes");

        // fairness from a fresh pointer: order 0,1,2,3,0,1 with one bubble between beats
        @(negedge wclk);
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        check("fair_trunc_after_rst", bus.o_trunc, 64'd0);
        s    = wr_cycs.size();
        base = wr_total;
        send(0, 32'hB0, 1'b1); send(0, 32'hB4, 1'b1);
        send(1, 32'hB1, 1'b1); send(1, 32'hB5, 1'b1);
        send(2, 32'hB2, 1'b1); send(3, 32'hB3, 1'b1);
        expect_beat(0, 32'hB0); expect_beat(1, 32'hB1); expect_beat(2, 32'hB2);
        expect_beat(3, 32'hB3); expect_beat(0, 32'hB4); expect_beat(1, 32'hB5);
        wait_wr(base + 6, 40, "fair_writes");
        if (wr_cycs.size() >= s + 6) begin
            for (int i = 1; i < 6; i++) begin
                check("fair_bubble", 64'(wr_cycs[s+i] - wr_cycs[s+i-1]), 64'd2);
            end
        end
        wait_idle(20, "fair_idle");

        // backpressure: FIFO of 8 fills mid-burst, drain resumes the burst
        rd_en = 1'b0;
        base  = wr_total;
        for (int i = 0; i < 12; i++) begin
            send(0, 32'hC0 + i, i == 11);
            expect_beat(0, 32'hC0 + i);
        end
        n = 0;
        while (bus.i_wfull !== 1'b1 && n < 40) begin
            @(negedge wclk);
            n++;
        end
        check("bp_full_seen", bus.i_wfull, 64'd1);
        check("bp_stall_wr", bus.o_wr, 64'd0);
        check("bp_stall_ready", bus.o_req_ready, 64'd0);
        check("bp_stall_busy", bus.o_busy, 64'd1);
        check("bp_stall_wdata", bus.o_wdata, {2'd0, 32'hC8});
        repeat (3) @(negedge wclk);
        #1;
        check("bp_held_writes", 64'(wr_total - base), 64'd8);
        rd_en = 1'b1;
        wait_wr(base + 12, 40, "bp_writes");
        wait_idle(40, "bp_idle");
        check("bp_trunc", bus.o_trunc, 64'd0);

        // truncation: requester 2 streams 20 beats without last until beat 20
        base = wr_total;
        for (int i = 0; i < 20; i++) send(2, 32'hD00 + i, i == 19);
        send(0, 32'hE0, 1'b1);
        send(3, 32'hE3, 1'b1);
        for (int i = 0; i < 16; i++) expect_beat(2, 32'hD00 + i);
        expect_beat(3, 32'hE3);
        expect_beat(0, 32'hE0);
        for (int i = 16; i < 20; i++) expect_beat(2, 32'hD00 + i);
        wait_wr(base + 16, 40, "trunc_first_grant");
        @(negedge wclk);
        check("trunc_release_busy", bus.o_busy, 64'd0);
        check("trunc_flag", bus.o_trunc, 64'h4);
        wait_wr(base + 22, 40, "trunc_writes");
        wait_idle(20, "trunc_idle");
        check("trunc_flag_final", bus.o_trunc, 64'h4);

        // abandon: requester 3 goes quiet after two beats
        base = wr_total;
        send(3, 32'hF0, 1'b0); send(3, 32'hF1, 1'b0);
        expect_beat(3, 32'hF0); expect_beat(3, 32'hF1);
        wait_wr(base + 2, 20, "abandon_writes");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wclk);
            if (bus.o_busy !== 1'b1) break;
            n++;
        end
        check("abandon_idle_cycles", 64'(n), 64'd8);
        check("abandon_busy", bus.o_busy, 64'd0);
        check("abandon_trunc", bus.o_trunc, 64'hC);

        // reset mid-burst: burst aborted, next grant to requester 0
        base = wr_total;
        send(2, 32'h10, 1'b0); send(2, 32'h11, 1'b0); send(2, 32'h12, 1'b0); send(2, 32'h13, 1'b1);
        expect_beat(2, 32'h10); expect_beat(2, 32'h11); expect_beat(0, 32'h20);
        expect_beat(2, 32'h12); expect_beat(2, 32'h13);
        wait_wr(base + 1, 20, "mid_rst_first");
        send(0, 32'h20, 1'b1);
        wait_wr(base + 2, 20, "mid_rst_second");
        @(posedge wclk);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_busy", bus.o_busy, 64'd0);
        check("mid_rst_wr", bus.o_wr, 64'd0);
        check("mid_rst_ready", bus.o_req_ready, 64'd0);
        check("mid_rst_gid", bus.o_grant_id, 64'd0);
        check("mid_rst_trunc", bus.o_trunc, 64'd0);
        #1;
        nrst = 1'b1;
        repeat (2) @(negedge wclk);
        check("mid_rst_next_busy", bus.o_busy, 64'd1);
        check("mid_rst_next_gid", bus.o_grant_id, 64'd0);
        wait_wr(base + 5, 30, "mid_rst_writes");
        wait_idle(20, "mid_rst_idle");
        check("final_trunc", bus.o_trunc, 64'd0);
        check("sb_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
